pwm_capture: RTL

- Measures an incoming PWM waveform, the receive-side counterpart of the fading-LED 8-bit PWM generator.
- Synchronises the input and counts period and high time in clock cycles.
- Converts the high/period ratio into an 8-bit duty code on the same 0..255 scale the generator takes.
- Flags a stuck-high or stuck-low input, and flags edges that arrive faster than the divider can handle.

---
 rtl/pwm_capture.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform and reports its period,
// its high time and an 8-bit duty code, floor(high*256/period), on the same
// 0..255 scale that the fading-LED PWM generator accepts.
//
// Ports:
//   clock      - system clock, all logic on posedge
//   reset      - asynchronous active-low reset
//   pwm_in     - asynchronous PWM input (synchronised internally)
//   period     - last measured period in clock cycles (0 after a stuck event)
//   high_time  - last measured high time in clock cycles (0 after a stuck event)
//   duty       - floor(high_time*256/period), or 255/0 when stuck high/low
//   duty_valid - one-cycle strobe whenever period/high_time/duty update
//   stuck      - no rising edge seen for 2^CNT_WIDTH-1 cycles
//   overrun    - sticky: a rising edge arrived while the divider was busy
module pwm_capture #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic [7:0]           duty,
    output logic                 duty_valid,
    output logic                 stuck,
    output logic                 overrun
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_ARM = 2'd0,
        ST_RUN = 2'd1,
        ST_DIV = 2'd2
    } state_t;

    state_t               state_r;
    logic                 s1_r;
    logic                 s2_r;
    logic                 s3_r;
    logic                 rise_s;
    logic                 cnt_sat_s;
    logic [CNT_WIDTH-1:0] period_cnt_r;
    logic [CNT_WIDTH-1:0] high_cnt_r;
    logic [CNT_WIDTH-1:0] p_r;
    logic [CNT_WIDTH-1:0] h_r;
    // One extra bit: the shifted remainder can reach up to 2*p-2.
    logic [CNT_WIDTH:0]   rem_r;
    logic [CNT_WIDTH:0]   rem2_s;
    logic [CNT_WIDTH:0]   rem_next_s;
    logic [7:0]           q_r;
    logic [7:0]           q_next_s;
    logic                 q_bit_s;
    logic [2:0]           step_r;

    // s2 is the synchronised level; s3 only serves edge detection.
    assign rise_s    = s2_r & ~s3_r;
    assign cnt_sat_s = (period_cnt_r == CNT_MAX);

    // Three-flop synchroniser for the asynchronous PWM input
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= pwm_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Period and high-time counters; they restart at every rise regardless of FSM state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period_cnt_r <= CNT_ZERO;
            high_cnt_r   <= CNT_ZERO;
        end else if (rise_s) begin
            // The rise cycle itself is the first high cycle of the new period.
            period_cnt_r <= CNT_ONE;
            high_cnt_r   <= CNT_ONE;
        end else begin
            if (period_cnt_r != CNT_MAX) begin
                period_cnt_r <= period_cnt_r + CNT_ONE;
            end
            if (s2_r && (high_cnt_r != CNT_MAX)) begin
                high_cnt_r <= high_cnt_r + CNT_ONE;
            end
        end
    end

    // One restoring-divider step: shift the partial remainder, trial-subtract p
    always_comb begin
        rem2_s     = rem_r << 1;
        rem_next_s = rem2_s;
        q_bit_s    = 1'b0;
        if (rem2_s >= {1'b0, p_r}) begin
            rem_next_s = rem2_s - {1'b0, p_r};
            q_bit_s    = 1'b1;
        end else begin
            rem_next_s = rem2_s;
            q_bit_s    = 1'b0;
        end
        q_next_s = {q_r[6:0], q_bit_s};
    end

    // Measurement FSM: arm on first rise, snapshot counters, divide, publish results
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_ARM;
            p_r        <= CNT_ZERO;
            h_r        <= CNT_ZERO;
            rem_r      <= {(CNT_WIDTH+1){1'b0}};
            q_r        <= 8'd0;
            step_r     <= 3'd0;
            period     <= CNT_ZERO;
            high_time  <= CNT_ZERO;
            duty       <= 8'd0;
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            case (state_r)
                ST_ARM: begin
                    // The first rise only marks the start of a period.
                    if (rise_s) begin
                        stuck   <= 1'b0;
                        state_r <= ST_RUN;
                    end else if (cnt_sat_s && !stuck) begin
                        // Only the first saturation reports; later cycles stay quiet.
                        stuck      <= 1'b1;
                        duty       <= s2_r ? 8'd255 : 8'd0;
                        period     <= CNT_ZERO;
                        high_time  <= CNT_ZERO;
                        duty_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A rise in the saturation cycle wins over the stuck report.
                    if (rise_s) begin
                        p_r     <= period_cnt_r;
                        h_r     <= high_cnt_r;
                        rem_r   <= {1'b0, high_cnt_r};
                        q_r     <= 8'd0;
                        step_r  <= 3'd0;
                        state_r <= ST_DIV;
                    end else if (cnt_sat_s) begin
                        stuck      <= 1'b1;
                        duty       <= s2_r ? 8'd255 : 8'd0;
                        period     <= CNT_ZERO;
                        high_time  <= CNT_ZERO;
                        duty_valid <= 1'b1;
                        state_r    <= ST_ARM;
                    end
                end
                ST_DIV: begin
                    // A rise now ends a period nobody will measure; the counters
                    // already restarted, so the next rise in RUN is valid again.
                    if (rise_s) begin
                        overrun <= 1'b1;
                    end
                    rem_r  <= rem_next_s;
                    q_r    <= q_next_s;
                    step_r <= step_r + 3'd1;
                    if (step_r == 3'd7) begin
                        // h < p guarantees the quotient fits in 8 bits.
                        period     <= p_r;
                        high_time  <= h_r;
                        duty       <= q_next_s;
                        duty_valid <= 1'b1;
                        state_r    <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_ARM;
                end
            endcase
        end
    end

endmodule
